// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: queues JK commands (op + repeat count) in a small FIFO and replays
// each one on registered j/k outputs. It also tracks the predicted Q of the downstream flop.
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [CNT_W-1:0] in_cnt,
  output logic             j,
  output logic             k,
  output logic             q_model,
  output logic             done,
  output logic             busy
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef struct packed {
    logic [1:0]       op;
    logic [CNT_W-1:0] cnt;
  } cmd_t;

  typedef enum logic {IDLE, RUN} state_t;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          ready_en;
  logic          push, pop, empty, full;
  cmd_t          head;

  state_t           state, state_next;
  logic [CNT_W-1:0] remaining, rem_next;
  logic [1:0]       jk_next;
  logic             done_next;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign in_ready = ready_en && !full;
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];
  assign busy     = (state == RUN) || !empty;

  // NOTE: the storage array has no reset; pointers and count alone say which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{op: in_op, cnt: in_cnt};
  end

  // ready_en holds in_ready low until the first edge after reset is released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    rem_next   = remaining;
    jk_next    = 2'b00;
    done_next  = 1'b0;
    pop        = 1'b0;
    if (state == RUN && remaining != CNT_W'(1)) begin
      rem_next  = remaining - CNT_W'(1);
      jk_next   = {j, k};
      done_next = (remaining == CNT_W'(2));
    end else begin
      // Idle, or the last cycle of a command: issue the head with no bubble.
      state_next = IDLE;
      if (!empty) begin
        pop      = 1'b1;
        rem_next = head.cnt;
        if (head.cnt == '0) begin
          done_next = 1'b1;
        end else begin
          state_next = RUN;
          jk_next    = head.op;
          done_next  = (head.cnt == CNT_W'(1));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      remaining <= '0;
      j         <= 1'b0;
      k         <= 1'b0;
      done      <= 1'b0;
      q_model   <= 1'b0;
    end else begin
      state     <= state_next;
      remaining <= rem_next;
      {j, k}    <= jk_next;
      done      <= done_next;
      case ({j, k})
        2'b01:   q_model <= 1'b0;
        2'b10:   q_model <= 1'b1;
        2'b11:   q_model <= ~q_model;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Bench for jk_cmd_sequencer: directed scenarios plus random traffic. Outputs are compared
// against a timeline model that expands each accepted command into its output slots.
module tb_jk_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_op = 2'b00;
  logic [CNT_W-1:0] in_cnt = '0;
  logic             j, k, q_model, done, busy;

  jk_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_cnt   (in_cnt),
    .j        (j),
    .k        (k),
    .q_model  (q_model),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int j_seen = 0;

  // One entry per output cycle still to come.
  typedef struct {
    logic [1:0] jk;
    logic       done;
    logic       run;
    logic       first;
  } slot_t;

  slot_t      sched[$];
  int         fifo_n = 0;
  logic       q_exp = 1'b0;
  logic [1:0] jk_exp = 2'b00;
  logic       done_exp = 1'b0;
  logic       run_exp = 1'b0;
  logic       ready_en_exp = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sched.delete();
    fifo_n       = 0;
    q_exp        = 1'b0;
    jk_exp       = 2'b00;
    done_exp     = 1'b0;
    run_exp      = 1'b0;
    ready_en_exp = 1'b0;
  endtask

  task automatic model_edge(input logic acc, input logic [1:0] op, input logic [CNT_W-1:0] cnt);
    slot_t s;
    case (jk_exp)
      2'b01:   q_exp = 1'b0;
      2'b10:   q_exp = 1'b1;
      2'b11:   q_exp = ~q_exp;
      default: ;
    endcase
    if (sched.size() > 0) begin
      s        = sched.pop_front();
      jk_exp   = s.jk;
      done_exp = s.done;
      run_exp  = s.run;
      if (s.first) fifo_n--;
    end else begin
      jk_exp   = 2'b00;
      done_exp = 1'b0;
      run_exp  = 1'b0;
    end
    if (acc) begin
      fifo_n++;
      if (cnt == '0) begin
        sched.push_back('{jk: 2'b00, done: 1'b1, run: 1'b0, first: 1'b1});
      end else begin
        for (int i = 0; i < int'(cnt); i++)
          sched.push_back('{jk: op, done: (i == int'(cnt) - 1), run: 1'b1, first: (i == 0)});
      end
    end
    ready_en_exp = 1'b1;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".j"},        32'(j),        32'(jk_exp[1]));
    check({tag, ".k"},        32'(k),        32'(jk_exp[0]));
    check({tag, ".done"},     32'(done),     32'(done_exp));
    check({tag, ".q_model"},  32'(q_model),  32'(q_exp));
    check({tag, ".busy"},     32'(busy),     32'(run_exp || fifo_n > 0));
    check({tag, ".in_ready"}, 32'(in_ready), 32'(ready_en_exp && fifo_n < DEPTH));
  endtask

  // Called at a negedge: drive inputs, cross one rising edge, compare at the next negedge.
  task automatic step(input logic v, input logic [1:0] op, input logic [CNT_W-1:0] cnt,
                      input string tag);
    logic acc;
    in_valid = v;
    in_op    = op;
    in_cnt   = cnt;
    acc      = v && ready_en_exp && (fifo_n < DEPTH);
    @(posedge clk);
    model_edge(acc, op, cnt);
    @(negedge clk);
    check_outputs(tag);
    if (done) done_seen++;
    if (j)    j_seen++;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, ".j"},        32'(j),        0);
    check({tag, ".k"},        32'(k),        0);
    check({tag, ".q_model"},  32'(q_model),  0);
    check({tag, ".done"},     32'(done),     0);
    check({tag, ".busy"},     32'(busy),     0);
    check({tag, ".in_ready"}, 32'(in_ready), 0);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b0;
    #1 reset_checks(tag);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 2'b00, '0, {tag, ".rel"});
    done_seen = 0;
    j_seen    = 0;
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 200 && (sched.size() > 0 || fifo_n > 0); n++)
      step(1'b0, 2'($urandom), CNT_W'($urandom), tag);
    step(1'b0, 2'b00, '0, tag);
    check({tag, ".idle_busy"}, 32'(busy), 0);
  endtask

  initial begin
    apply_reset("rst0");

    // Single set command, cnt=3.
    step(1'b1, 2'b10, 4'd3, "single");
    drain("single");
    check("single.dones", done_seen, 1);
    check("single.jcyc", j_seen, 3);
    check("single.q", 32'(q_model), 1);

    // Toggle parity with odd and even counts.
    apply_reset("rst1");
    step(1'b1, 2'b11, 4'd5, "tog5");
    drain("tog5");
    check("tog5.q", 32'(q_model), 1);
    check("tog5.dones", done_seen, 1);
    apply_reset("rst2");
    step(1'b1, 2'b11, 4'd4, "tog4");
    drain("tog4");
    check("tog4.q", 32'(q_model), 0);

    // Back-to-back commands with no idle gap.
    apply_reset("rst3");
    step(1'b1, 2'b10, 4'd2, "b2b");
    step(1'b1, 2'b01, 4'd1, "b2b");
    step(1'b1, 2'b11, 4'd3, "b2b");
    drain("b2b");
    check("b2b.dones", done_seen, 3);

    // FIFO full: a long command stalls issue while DEPTH more are queued.
    apply_reset("rst4");
    step(1'b1, 2'b10, 4'd15, "full");
    step(1'b1, 2'b01, 4'd2, "full");
    step(1'b1, 2'b00, 4'd1, "full");
    step(1'b1, 2'b11, 4'd3, "full");
    step(1'b1, 2'b10, 4'd1, "full");
    check("full.ready_low", 32'(in_ready), 0);
    step(1'b1, 2'b11, 4'd7, "full.reject");
    step(1'b1, 2'b11, 4'd7, "full.reject");
    in_valid = 1'b0;
    drain("full");
    check("full.dones", done_seen, 5);

    // Zero count: a no-op slot that still pulses done.
    apply_reset("rst5");
    step(1'b1, 2'b11, 4'd0, "zero");
    step(1'b1, 2'b10, 4'd1, "zero");
    drain("zero");
    check("zero.dones", done_seen, 2);
    check("zero.jcyc", j_seen, 1);
    check("zero.q", 32'(q_model), 1);

    // Asynchronous reset during a running toggle with two commands queued.
    apply_reset("rst6");
    step(1'b1, 2'b11, 4'd8, "midrst");
    step(1'b1, 2'b10, 4'd2, "midrst");
    step(1'b1, 2'b01, 4'd2, "midrst");
    in_valid = 1'b0;
    #1 rst = 1'b0;
    #1 reset_checks("midrst.async");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    done_seen = 0;
    j_seen    = 0;
    for (int n = 0; n < 6; n++) step(1'b0, 2'b00, '0, "midrst.after");
    check("midrst.ready", 32'(in_ready), 1);
    check("midrst.dones", done_seen, 0);
    check("midrst.jcyc", j_seen, 0);

    // Random traffic against the model.
    apply_reset("rst7");
    for (int n = 0; n < 400; n++) begin
      logic [CNT_W-1:0] c;
      c = ($urandom_range(0, 7) == 0) ? CNT_W'($urandom_range(0, 15))
                                       : CNT_W'($urandom_range(0, 3));
      step($urandom_range(0, 2) != 0, 2'($urandom), c, "rand");
    end
    in_valid = 1'b0;
    drain("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_cmd_sequencer.md
Name: jk_cmd_sequencer

Overview:
- Upstream driver for a JK flip-flop stage; generates its j/k inputs.
- Accepts JK commands (hold/reset/set/toggle, each with a repeat count) over a valid/ready interface and buffers them in a small FIFO.
- Replays each command on registered j/k outputs for exactly the requested number of cycles.
- Keeps a local model of the downstream Q so the bench and system can check the expected flop state.

Parameters:
- DEPTH, 4: command FIFO entries; power of two, >= 2.
- CNT_W, 4: width of the repeat count; maximum repeat is 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset; low = reset.
- in_valid  input  1  a command is offered.
- in_ready  output  1  the FIFO can accept a command.
- in_op  input  2  {j,k} pattern: 00 hold, 01 reset, 10 set, 11 toggle.
- in_cnt  input  CNT_W  number of cycles to drive in_op.
- j  output  1  registered J to the downstream flop.
- k  output  1  registered K to the downstream flop.
- q_model  output  1  predicted downstream Q.
- done  output  1  one-cycle pulse when a command completes.
- busy  output  1  a command is executing or the FIFO is non-empty.

Behaviour:
- Reset (rst low, asynchronous):
  - FIFO pointers and count are cleared; FSM goes to IDLE.
  - j=0, k=0, q_model=0, done=0, busy=0, in_ready=0.
  - The in-flight command and all queued commands are discarded.
  - in_ready rises in the first cycle after rst deasserts.
- FIFO:
  - in_ready = !full, outside reset.
  - A push occurs on a rising edge where in_valid && in_ready.
  - There is no bypass: when full, in_ready=0 even if a pop happens in the same cycle.
  - Push and pop in the same edge are legal when neither full nor empty; the count is unchanged.
  - Pointers wrap modulo DEPTH.
  - Ordering is strictly FIFO.
- FSM states: IDLE, RUN.
- IDLE:
  - j=k=0 and done=0.
  - If the FIFO is non-empty at an edge, pop the head and load op and remaining=cnt.
  - If cnt != 0, go to RUN.
  - If cnt == 0, stay in IDLE and pulse done in the next cycle with j=k=0. The zero-count command occupies one issue slot.
- RUN:
  - {j,k}=op for the current cycle.
  - remaining decrements at each edge.
  - In the cycle where remaining == 1, done=1 (coincident with the last op cycle).
  - At that edge, if the FIFO is non-empty, pop the next command with no bubble. Its first op cycle immediately follows, or a zero-count command handles as in IDLE.
  - If the FIFO is empty at that edge, go to IDLE and drive j=k=0 from the next cycle.
- Latency:
  - A command accepted at edge E0 into an empty, idle block drives j/k from edge E0+1.
  - It lasts exactly cnt cycles.
  - The first op cycle is therefore the cycle after the accept-edge cycle.
- j, k and done are flop outputs with no combinational path from inputs.
- q_model is updated at every edge from the current j/k values:
  - 00 hold
  - 01 -> 0
  - 10 -> 1
  - 11 -> invert
- busy = (state==RUN) || !empty.
- Hold commands (op=00) are executed normally. They occupy cycles, and done pulses at completion.
- in_op and in_cnt are ignored when no push occurs.
- Reset during RUN: j/k drop to 0 immediately and asynchronously, and no done pulse is generated.

Test Plan:
- Reset then single command: op=10, cnt=3 accepted at edge 0.
  - j=1, k=0 for cycles 1-3; done=1 in cycle 3.
  - j=k=0 from cycle 4; q_model=1 from the end of cycle 1.
- Toggle parity: op=11, cnt=5.
  - q_model toggles 0→1→0→1→0→1; final q_model=1; done exactly once.
  - Repeat with cnt=4 → final q_model=0.
- Back-to-back: push 10/cnt2, 01/cnt1, 11/cnt3 on consecutive edges.
  - j/k sequence is 10,10,01,11,11,11 with no idle cycle.
  - done pulses in cycles 2, 3 and 6; busy deasserts after the final cycle.
- FIFO full: stall the issue path by loading a cnt=15 command, then push DEPTH more.
  - in_ready=0 after 4 queued pushes; a 5th in_valid is not accepted.
  - in_ready returns 1 the cycle after the first pop; all commands are executed in order.
- Zero count: push op=11, cnt=0, then op=10, cnt=1.
  - No toggle occurs; done pulses twice.
  - j=1 for exactly one cycle; q_model ends at 1.
- Reset mid-operation: assert rst low during cycle 2 of a cnt=8 toggle with 2 commands queued.
  - j=k=0 and q_model=0 immediately; busy=0.
  - After release, no queued command executes, and in_ready=1 the next cycle.
